// File: rtl/serial_rx_pkg.sv
// Shared types and default sizing for the oversampling serial receiver.
package serial_rx_pkg;

  localparam int DEFAULT_NUM_DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_rx_flex_stp_sr.sv
// Parameterized serial-to-parallel shifter; SHIFT_MSB selects which end the
// first received bit ends up in once NUM_BITS shifts have completed.
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      parallel_out <= '1;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
      end else begin
        parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Oversampling serial receiver: synchronizer, start/data/stop FSM, output
// buffer with ready/read handshake, framing and overrun error flags.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEFAULT_NUM_DATA_BITS,
  parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
  parameter bit SHIFT_MSB     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  input  logic                     data_read,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     framing_error,
  output logic                     overrun_error
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = $clog2(NUM_DATA_BITS + 1);

  localparam logic [TIMER_W-1:0] START_SAMPLE = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST     = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT     = CNT_W'(NUM_DATA_BITS - 1);

  logic                     sync_q1;
  logic                     sync_q2;
  logic                     sync_prev;
  rx_state_t                state;
  logic [TIMER_W-1:0]       timer;
  logic [CNT_W-1:0]         bit_cnt;
  logic                     shift_enable;
  logic [NUM_DATA_BITS-1:0] shift_data;

  // Reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_q1   <= serial_in;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  assign shift_enable = (state == DATA) && (timer == BIT_LAST);

  flex_stp_sr #(
    .NUM_BITS (NUM_DATA_BITS),
    .SHIFT_MSB(SHIFT_MSB)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .shift_enable(shift_enable),
    .serial_in   (sync_q2),
    .parallel_out(shift_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      rx_data       <= '1;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      // Consumer acknowledge; a good-frame load below overrides data_ready.
      if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      timer <= timer + 1'b1;

      unique case (state)
        IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (!sync_q2 && sync_prev) begin
            state <= START;
          end
        end

        START: begin
          if (timer == START_SAMPLE) begin
            timer   <= '0;
            bit_cnt <= '0;
            if (!sync_q2) begin
              framing_error <= 1'b0;
              state         <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end

        DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            state <= IDLE;
            if (sync_q2) begin
              rx_data    <= shift_data;
              data_ready <= 1'b1;
              // A coincident read acknowledges the old word, so no overrun.
              if (data_ready && !data_read) begin
                overrun_error <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed plus randomized frames against a frame-level model of the receiver's
// outputs, with exact-edge checks around every stop-bit sample.
module tb_serial_rx;

  localparam int NB  = 8;
  localparam int CPB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          data_read;
  logic [NB-1:0] rx_data;
  logic          data_ready;
  logic          framing_error;
  logic          overrun_error;

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] exp_data;
  logic          exp_ready;
  logic          exp_fe;
  logic          exp_ov;

  serial_rx #(
    .NUM_DATA_BITS(NB),
    .CLKS_PER_BIT (CPB),
    .SHIFT_MSB    (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rx_data"},       32'(rx_data),       32'(exp_data));
    check({tag, ".data_ready"},    32'(data_ready),    32'(exp_ready));
    check({tag, ".framing_error"}, 32'(framing_error), 32'(exp_fe));
    check({tag, ".overrun_error"}, 32'(overrun_error), 32'(exp_ov));
  endtask

  task automatic model_reset();
    exp_data  = '1;
    exp_ready = 1'b0;
    exp_fe    = 1'b0;
    exp_ov    = 1'b0;
  endtask

  // Outcome of one completed frame, from the receiver's rules.
  task automatic model_frame(input logic [NB-1:0] d, input logic stop, input logic rd);
    if (stop) begin
      if (exp_ready) exp_ov = !rd;
      exp_data  = d;
      exp_ready = 1'b1;
    end else begin
      exp_fe = 1'b1;
      if (rd && exp_ready) begin
        exp_ready = 1'b0;
        exp_ov    = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic read_pulse(input string tag);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    if (exp_ready) begin
      exp_ready = 1'b0;
      exp_ov    = 1'b0;
    end
    check_all(tag);
  endtask

  // Start bit is driven just before edge k; the stop sample lands on edge k+97.
  task automatic send_frame(input string tag, input logic [NB-1:0] d, input logic stop,
                            input logic rd_at_load);
    drive_bit(1'b0);
    for (int i = NB - 1; i >= 0; i--) drive_bit(d[i]);
    serial_in = stop;
    for (int j = 0; j < CPB; j++) begin
      @(negedge clk);
      if (j == 6) begin
        exp_fe = 1'b0;
        check_all({tag, ".pre"});
        if (rd_at_load) data_read = 1'b1;
      end
      if (j == 7) begin
        data_read = 1'b0;
        model_frame(d, stop, rd_at_load);
        check_all({tag, ".load"});
      end
    end
    serial_in = 1'b1;
  endtask

  initial begin
    logic [NB-1:0] abort_word;
    logic [NB-1:0] rd_word;
    logic          rd_stop;
    logic          rd_load;

    rst       = 1'b1;
    serial_in = 1'b1;
    data_read = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset");
    idle(50);
    check_all("idle50");

    send_frame("a5", 8'hA5, 1'b1, 1'b0);
    idle(4);
    read_pulse("a5_read");
    read_pulse("read_when_empty");

    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    check_all("glitch");
    send_frame("3c_after_glitch", 8'h3C, 1'b1, 1'b0);
    idle(3);
    read_pulse("3c_read");

    send_frame("81", 8'h81, 1'b1, 1'b0);
    idle(5);
    send_frame("3c_bad_stop", 8'h3C, 1'b0, 1'b0);
    idle(15);
    check_all("fe_held");
    send_frame("5a_after_fe", 8'h5A, 1'b1, 1'b0);
    idle(2);
    read_pulse("5a_read");

    send_frame("ovr_11", 8'h11, 1'b1, 1'b0);
    idle(5);
    send_frame("ovr_22", 8'h22, 1'b1, 1'b0);
    idle(2);
    read_pulse("ovr_read");
    send_frame("b2b_11", 8'h11, 1'b1, 1'b0);
    send_frame("b2b_22_rd", 8'h22, 1'b1, 1'b1);
    idle(2);
    read_pulse("b2b_read");

    send_frame("pre_abort", 8'h99, 1'b1, 1'b0);
    idle(6);
    abort_word = 8'hC3;
    drive_bit(1'b0);
    for (int i = NB - 1; i > NB - 4; i--) drive_bit(abort_word[i]);
    serial_in = abort_word[NB-4];
    repeat (5) @(negedge clk);
    rst       = 1'b1;
    serial_in = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("rst_mid_frame");
    rst = 1'b0;
    idle(30);
    check_all("after_rst_idle");
    send_frame("5a_after_rst", 8'h5A, 1'b1, 1'b0);
    idle(3);
    read_pulse("5a_rst_read");

    for (int n = 0; n < 24; n++) begin
      rd_word = NB'($urandom);
      rd_stop = ($urandom_range(3) != 0);
      rd_load = ($urandom_range(4) == 0);
      send_frame($sformatf("rnd%0d", n), rd_word, rd_stop, rd_load);
      if ($urandom_range(2) == 0) read_pulse($sformatf("rnd%0d_read", n));
      idle($urandom_range(0, 25));
    end
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
